sdram_lfsr_tester: RTL and testbench

- Consumer of the 22-bit LFSR pattern generator in the SDRAM test project.
- Writes a pseudo-random pattern across an address range and reseeds the LFSR, so the read pass sees the identical sequence.
- Reads the range back, compares every word against the regenerated pattern and reports pass/fail plus a saturating error count.
- Sits between the LFSR and the SDRAM controller's simple request/acknowledge port.

---
 rtl/sdram_test_pkg.sv | 16 +
 rtl/simplelfsr.sv | 31 +++
 rtl/sdram_lfsr_tester.sv | 163 ++++++++++++++++
 tb/tb_sdram_lfsr_tester.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM LFSR pattern tester.
package sdram_test_pkg;

    localparam int LFSR_W = 22;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 22'd4;

    typedef enum logic [2:0] {
        IDLE,
        SEEDW,
        WRITE,
        SEEDR,
        READ,
        DONE
    } state_t;

endpackage

// File: rtl/simplelfsr.sv
// 22-bit Fibonacci LFSR (x^22 + x^21 + 1) with synchronous reseed to LFSR_SEED.
module simplelfsr
    import sdram_test_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    output logic [OUT_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (reset) begin
            lfsr_d = LFSR_SEED;
        end else if (ena) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2]};
        end
    end

    always_ff @(posedge clk) begin
        lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/sdram_lfsr_tester.sv
// Writes an LFSR pattern over 0..last_addr, reseeds, reads it back and counts mismatches.
// Define SDRAM_TEST_ERRLOG_EN to add first-mismatch capture outputs.
module sdram_lfsr_tester
    import sdram_test_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
`ifdef SDRAM_TEST_ERRLOG_EN
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_got,
`endif
    output logic [ERR_W-1:0]  err_count
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              pass_q, pass_d;
    logic              lfsr_rst;
    logic              lfsr_ena;
    logic [DATA_W-1:0] pattern;
`ifdef SDRAM_TEST_ERRLOG_EN
    logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
    logic [DATA_W-1:0] fe_exp_q, fe_exp_d;
    logic [DATA_W-1:0] fe_got_q, fe_got_d;
`endif

    simplelfsr #(.OUT_W(DATA_W)) u_lfsr (
        .clk   (clk),
        .reset (lfsr_rst),
        .ena   (lfsr_ena),
        .q     (pattern)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        last_d   = last_q;
        err_d    = err_q;
        pass_d   = pass_q;
        lfsr_rst = 1'b0;
        lfsr_ena = 1'b0;
`ifdef SDRAM_TEST_ERRLOG_EN
        fe_addr_d = fe_addr_q;
        fe_exp_d  = fe_exp_q;
        fe_got_d  = fe_got_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    last_d  = last_addr;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    state_d = SEEDW;
`ifdef SDRAM_TEST_ERRLOG_EN
                    fe_addr_d = '0;
                    fe_exp_d  = '0;
                    fe_got_d  = '0;
`endif
                end
            end
            SEEDW, SEEDR: begin
                lfsr_rst = 1'b1;
                addr_d   = '0;
                state_d  = (state_q == SEEDW) ? WRITE : READ;
            end
            WRITE: begin
                if (mem_ack) begin
                    lfsr_ena = 1'b1;
                    if (addr_q == last_q) begin
                        state_d = SEEDR;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            READ: begin
                if (mem_ack) begin
                    lfsr_ena = 1'b1;
                    if (mem_rdata != pattern) begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_W'(1);
                        end
`ifdef SDRAM_TEST_ERRLOG_EN
                        // A zero count means this is the first mismatch of the run.
                        if (err_q == '0) begin
                            fe_addr_d = addr_q;
                            fe_exp_d  = pattern;
                            fe_got_d  = mem_rdata;
                        end
`endif
                    end
                    // Terminal test precedes the increment so last_addr = all-ones never wraps.
                    if (addr_q == last_q) begin
                        state_d = DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
`ifdef SDRAM_TEST_ERRLOG_EN
            fe_addr_q <= '0;
            fe_exp_q  <= '0;
            fe_got_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
`ifdef SDRAM_TEST_ERRLOG_EN
            fe_addr_q <= fe_addr_d;
            fe_exp_q  <= fe_exp_d;
            fe_got_q  <= fe_got_d;
`endif
        end
    end

    assign mem_req   = (state_q == WRITE) || (state_q == READ);
    assign mem_wr    = (state_q == WRITE);
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = mem_wr ? pattern : '0;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
`ifdef SDRAM_TEST_ERRLOG_EN
    assign first_err_addr = fe_addr_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_got  = fe_got_q;
`endif

endmodule

// File: tb/tb_sdram_lfsr_tester.sv
// Directed bench for sdram_lfsr_tester: ideal memory model plus a 2-bit-counter instance.
module tb_sdram_lfsr_tester;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start, mem_ack, mem_req, mem_wr, busy, done, pass;
    logic [21:0] last_addr, mem_addr;
    logic [15:0] mem_wdata, mem_rdata, err_count;
`ifdef SDRAM_TEST_ERRLOG_EN
    logic [21:0] fe_addr;
    logic [15:0] fe_exp, fe_got;
`endif

    logic        start_b, mem_ack_b, mem_req_b, mem_wr_b, busy_b, done_b, pass_b;
    logic [21:0] last_addr_b, mem_addr_b;
    logic [15:0] mem_wdata_b, mem_rdata_b;
    logic [1:0]  err_count_b;
`ifdef SDRAM_TEST_ERRLOG_EN
    logic [21:0] fe_addr_b;
    logic [15:0] fe_exp_b, fe_got_b;
`endif

    sdram_lfsr_tester dut (
        .clk(clk), .reset(rst), .start(start), .last_addr(last_addr),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
`ifdef SDRAM_TEST_ERRLOG_EN
        .first_err_addr(fe_addr), .first_err_exp(fe_exp), .first_err_got(fe_got),
`endif
        .err_count(err_count)
    );

    sdram_lfsr_tester #(.ERR_W(2)) dut_b (
        .clk(clk), .reset(rst), .start(start_b), .last_addr(last_addr_b),
        .mem_req(mem_req_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b), .busy(busy_b), .done(done_b), .pass(pass_b),
`ifdef SDRAM_TEST_ERRLOG_EN
        .first_err_addr(fe_addr_b), .first_err_exp(fe_exp_b), .first_err_got(fe_got_b),
`endif
        .err_count(err_count_b)
    );

    int vec_cnt = 0;
    int miscompares = 0;

    logic [15:0] mem [0:15];
    int          flip_addr = -1;
    int          stall_left = 0;
    logic [21:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    int          rd_cnt = 0;
    int          wr_cnt_b = 0;
    int          rd_cnt_b = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model for the main instance: ack one cycle after a request is seen.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack && mem_req) begin
                if (mem_wr) begin
                    mem[mem_addr[3:0]] = mem_wdata;
                    wr_addr_log.push_back(mem_addr);
                    wr_data_log.push_back(mem_wdata);
                    $display("[%0t] A wr addr=%0d data=0x%04h", $time, mem_addr, mem_wdata);
                end else begin
                    rd_cnt++;
                    $display("[%0t] A rd addr=%0d data=0x%04h", $time, mem_addr, mem_rdata);
                end
            end
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (stall_left > 0 && mem_wr && mem_addr == 22'd1) begin
                    stall_left--;
                end else begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_wr ? 16'h0 :
                                (mem[mem_addr[3:0]] ^ ((int'(mem_addr) == flip_addr) ? 16'h1 : 16'h0));
                end
            end
        end
    end

    // Model for the second instance: every read returns zero, so every compare misses.
    initial begin
        mem_ack_b   = 1'b0;
        mem_rdata_b = '0;
        forever begin
            @(negedge clk);
            if (mem_ack_b && mem_req_b) begin
                if (mem_wr_b) wr_cnt_b++;
                else          rd_cnt_b++;
                $display("[%0t] B %s addr=%0d", $time, mem_wr_b ? "wr" : "rd", mem_addr_b);
            end
            @(posedge clk);
            #1;
            mem_ack_b = !mem_ack_b && mem_req_b;
        end
    end

    task automatic start1(input logic [21:0] last);
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_cnt    = 0;
        last_addr = last;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done1(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_reached", done, 1'b1);
    endtask

    task automatic check_writes4(input string tag);
        logic [15:0] exp_pat [4];
        exp_pat = '{16'h0004, 16'h0008, 16'h0010, 16'h0020};
        check_eq({tag, "_wr_count"}, wr_data_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_data_log.size(); i++) begin
            check_eq({tag, "_wr_addr"}, wr_addr_log[i], i);
            check_eq({tag, "_wr_data"}, wr_data_log[i], exp_pat[i]);
        end
        check_eq({tag, "_rd_count"}, rd_cnt, 4);
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        start       = 1'b0;
        last_addr   = '0;
        start_b     = 1'b0;
        last_addr_b = '0;
        repeat (3) @(negedge clk);

        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_wr", mem_wr, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_pass", pass, 1'b0);
        check_eq("rst_err", err_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Clean run over 0..3 with latency checks.
        start1(22'd3);
        check_eq("lat_busy", busy, 1'b1);
        check_eq("lat_req_seed", mem_req, 1'b0);
        @(negedge clk);
        check_eq("lat_req", mem_req, 1'b1);
        check_eq("lat_wr", mem_wr, 1'b1);
        check_eq("lat_addr", mem_addr, 0);
        check_eq("lat_wdata", mem_wdata, 16'h0004);
        wait_done1(200);
        check_writes4("clean");
        check_eq("clean_pass", pass, 1'b1);
        check_eq("clean_err", err_count, 0);
        check_eq("clean_busy", busy, 1'b0);
        check_eq("clean_req", mem_req, 1'b0);

        // Bit 0 flipped on read of address 2.
        flip_addr = 2;
        start1(22'd3);
        wait_done1(200);
        check_eq("flip_err", err_count, 1);
        check_eq("flip_pass", pass, 1'b0);
`ifdef SDRAM_TEST_ERRLOG_EN
        check_eq("flip_fe_addr", fe_addr, 2);
        check_eq("flip_fe_exp", fe_exp, 16'h0010);
        check_eq("flip_fe_got", fe_got, 16'h0011);
`endif
        flip_addr = -1;

        // Single-word range.
        start1(22'd0);
        wait_done1(100);
        check_eq("one_wr_count", wr_data_log.size(), 1);
        if (wr_data_log.size() > 0) begin
            check_eq("one_wr_data", wr_data_log[0], 16'h0004);
            check_eq("one_wr_addr", wr_addr_log[0], 0);
        end
        check_eq("one_rd_count", rd_cnt, 1);
        check_eq("one_pass", pass, 1'b1);
`ifdef SDRAM_TEST_ERRLOG_EN
        check_eq("one_fe_cleared", fe_addr, 0);
`endif

        // Ack withheld for five extra cycles on the second write.
        stall_left = 5;
        start1(22'd3);
        n = 0;
        while (!(mem_req && mem_wr && mem_addr == 22'd1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("stall_seen", mem_addr, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("stall_ack", mem_ack, 1'b0);
            check_eq("stall_req", mem_req, 1'b1);
            check_eq("stall_addr", mem_addr, 1);
            check_eq("stall_wdata", mem_wdata, 16'h0008);
        end
        wait_done1(200);
        check_writes4("stall");
        check_eq("stall_pass", pass, 1'b1);

        // Async reset during the read pass, then a clean rerun.
        start1(22'd3);
        n = 0;
        while (!(mem_req && !mem_wr) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("in_read", mem_req && !mem_wr, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_req", mem_req, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start1(22'd3);
        wait_done1(200);
        check_writes4("rerun");
        check_eq("rerun_pass", pass, 1'b1);
        check_eq("rerun_err", err_count, 0);

        // Two-bit counter saturates; a start while busy is ignored.
        last_addr_b = 22'd7;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (10) @(negedge clk);
        last_addr_b = 22'd1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check_eq("b_busy_after_start", busy_b, 1'b1);
        n = 0;
        while (!done_b && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("b_done", done_b, 1'b1);
        check_eq("b_err_sat", err_count_b, 2'd3);
        check_eq("b_pass", pass_b, 1'b0);
        check_eq("b_wr_count", wr_cnt_b, 8);
        check_eq("b_rd_count", rd_cnt_b, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
